// File: rtl/mux2_pkg.sv
// Shared definitions for the mux2 datapath stage and its round-robin front end.
package mux2_pkg;

  localparam int BIT_DEFAULT = 4;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef logic [7:0] xfer_cnt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux2.sv
// Plain 2:1 word multiplexer; sel=0 passes in0, sel=1 passes in1.
module mux2 #(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0] in1,
  input  logic [BIT-1:0] in0,
  input  logic           sel,
  output logic [BIT-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_arb.sv
// Round-robin arbiter for two valid/ready sources feeding a mux2, with a
// single-entry registered output and saturating per-source transfer counters.
module mux2_arb
  import mux2_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BIT-1:0] in0,
  input  logic           in0_valid,
  output logic           in0_ready,
  input  logic [BIT-1:0] in1,
  input  logic           in1_valid,
  output logic           in1_ready,
  output logic           sel,
  output logic [BIT-1:0] out,
  output logic           out_valid,
  input  logic           out_ready,
  output xfer_cnt_t      cnt0,
  output xfer_cnt_t      cnt1
);

  out_state_t     state_q, state_d;
  logic [BIT-1:0] data_q, data_d;
  logic           last_sel_q, last_sel_d;
  xfer_cnt_t      cnt0_q, cnt0_d;
  xfer_cnt_t      cnt1_q, cnt1_d;

  logic           load_en;
  logic           grant;
  logic           accept;
  logic [BIT-1:0] mux_out;

  mux2 #(.BIT(BIT)) u_mux2 (
    .in1 (in1),
    .in0 (in0),
    .sel (grant),
    .out (mux_out)
  );

  // With no contender the grant parks on the last winner; a tie goes to the other side.
  always_comb begin
    grant = last_sel_q;
    unique case ({in1_valid, in0_valid})
      2'b01:   grant = SEL_IN0;
      2'b10:   grant = SEL_IN1;
      2'b11:   grant = ~last_sel_q;
      default: grant = last_sel_q;
    endcase
  end

  assign load_en   = (state_q == OUT_EMPTY) || out_ready;
  assign in0_ready = !rst && load_en && (grant == SEL_IN0);
  assign in1_ready = !rst && load_en && (grant == SEL_IN1);
  assign accept    = (grant == SEL_IN0) ? (in0_valid && in0_ready)
                                        : (in1_valid && in1_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OUT_EMPTY;
      data_q     <= '0;
      last_sel_q <= SEL_IN1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_sel_q <= last_sel_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_sel_d = last_sel_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (load_en) begin
      state_d = accept ? OUT_FULL : OUT_EMPTY;
    end
    if (accept) begin
      data_d     = mux_out;
      last_sel_d = grant;
      if (grant == SEL_IN0) begin
        if (cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
      end else begin
        if (cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
      end
    end
  end

  always_comb begin
    sel       = grant;
    out       = data_q;
    out_valid = (state_q == OUT_FULL);
    cnt0      = cnt0_q;
    cnt1      = cnt1_q;
  end

endmodule
